conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Hardware instruction sequencer that replaces the hand-written stimulus loop driving `core`. It emits the 34-bit `inst` word cycle by cycle for one full convolution tile: activation preload, then per-kij core reset, weight write, IFIFO fill, weight load, L0 fill, execute and OFIFO drain, then the final psum accumulation. It is parametrised in array size and spatial geometry. Unlike the fixed stimulus flow, it computes accumulation addresses itself, supports activation reuse and stalls on an upstream data handshake.

## Interface
- `row`, 8: PE rows (input channels).
- `col`, 8: PE columns (output channels).
- `in_w`, 6: input feature-map width; `len_nij = in_w*in_w`.
- `k_w`, 3: kernel width; `len_kij = k_w*k_w`, `out_w = in_w-k_w+1`, `len_onij = out_w*out_w`.
- `wgt_base`, 1024: xmem base address for weights.
- `rst_cycles`, 11: core-reset length before each kij.

Ports, clock and reset first:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle launch request; sampled only in IDLE.
- `skip_act` in 1: sampled together with `start`; 1 skips ACT_WR.
- `inst` out 34: registered instruction word, same bit map as `core`.
  - [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem.
  - [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem.
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
- `core_reset` out 1: registered reset to `core`.
- `data_req` out 1: an xmem write slot is being offered.
- `data_kind` out 1: 0 for activation, 1 for weight.
- `data_idx` out 11: word index (nij, or kij*col+t).
- `data_ack` in 1: provider drives D_xmem this cycle.
- `busy` out 1: high from the cycle after `start` until `done`.
- `done` out 1: one-cycle pulse at the end of the run.
- `out_strobe` out 1: one-cycle pulse when `sfp_out` holds output `out_idx`.
- `out_idx` out 5: onij index of the current output.

## Operation
- NOP word = 34'h1800C0000 (both CEN/WEN pairs at 1, everything else 0).
- State sequence: IDLE → ACT_WR → {KRST → W_WR → W_FIFO → W_LOAD → W_DRAIN → L0_WR → EXEC → GAP → OFIFO_RD} ×len_kij → {ACC_RST → ACC_RD → ACC_END} ×len_onij → IDLE.
- ACT_WR: len_nij writes (CEN_x=0, WEN_x=0) to A_xmem = nij.
- KRST: `core_reset`=1 for rst_cycles, then 1 cycle with NOP.
- W_WR: col writes to A_xmem = wgt_base+t.
- W_FIFO: col+1 cycles, ififo_wr=1, read at A_xmem = wgt_base+t.
- W_LOAD: col cycles, ififo_rd=1 and load=1.
- W_DRAIN: 1+row+col cycles, load=1, ififo_rd=0.
- L0_WR: len_nij+1 cycles, l0_wr=1, read at A_xmem = t (0..len_nij).
- EXEC: len_nij+row+col cycles, l0_rd=1 and execute=1.
- GAP: 1 NOP cycle.
- OFIFO_RD: len_nij cycles, ofifo_rd=1, CEN_p=0, WEN_p=0, A_pmem = kij*len_nij+t.
- ACC_RST: 1 cycle of `core_reset`=1.
- ACC_RD: len_kij+1 cycles, j=0..len_kij.
  - For j<len_kij: CEN_p=0, WEN_p=1, A_pmem = kij*len_nij + (oy+ky)*in_w + (ox+kx), with kij=j, ky=j/k_w, kx=j%k_w, oy=o/out_w, ox=o%out_w.
  - For j=len_kij: CEN_p=1.
  - acc=1 for j≥1.
- ACC_END: acc=0.
- All fields not listed for a state take their NOP value.
- Handshake: the write slot is live in ACT_WR and W_WR only.
  - `data_req`=1 with `data_idx` valid.
  - If `data_ack`=0, `inst` is NOP for that cycle and the index holds, i.e. the cycle is a stall with no write.
- Address arithmetic is unsigned 11-bit. Parameters must keep every address below 2048; this is not checked in hardware.
- `start` while `busy` is ignored.

## Timing
- Reset values: `inst`=NOP, `core_reset`=0, `data_req`=0, `data_kind`=0, `data_idx`=0, `busy`=0, `done`=0, `out_strobe`=0, `out_idx`=0; state is IDLE.
- `reset` mid-run returns to IDLE on the next edge with all outputs at their reset values; there is no partial completion and no `done`.
- `start` sampled at edge N: `busy`=1 and the first ACT_WR `inst` are valid after edge N+1.
- `inst` and `core_reset` are registered; `core` applies its own input register on top.
- Per-kij length with no stalls: (rst_cycles+1) + col + (col+1) + col + (1+row+col) + (len_nij+1) + (len_nij+row+col) + 1 + len_nij. With the defaults this is 180 cycles.
- Each accumulated output takes len_kij+3 cycles.
- Default run with no stalls and skip_act=0: busy high for 36 + 9×180 + 16×12 = 1848 cycles. With skip_act=1 it is 1812 cycles.
- `done` pulses in the first IDLE cycle after the run; `busy` drops in that same cycle.
- `out_strobe` pulses in the cycle after ACC_END, with `out_idx`=o.
- Each stalled cycle adds exactly 1 cycle to the run.

## Test plan
- Reset for 3 cycles → `inst`=34'h1800C0000 and all other outputs 0.
- Default parameters, `start`, `data_ack` held 1:
  - `busy` high for exactly 1848 cycles, then a single `done` pulse.
  - 16 `out_strobe` pulses with `out_idx` 0..15.
  - 36 activation and 72 weight writes, weights at xmem 1024..1031.
- `skip_act`=1 → no `data_kind`=0 requests; `busy` lasts 1812 cycles.
- Accumulation address for o=5, j=4 → A_pmem=158. For o=15, j=8 → A_pmem=323.
- `data_ack` low for 5 cycles at W_WR t=3:
  - 5 NOP cycles, `data_idx` held at 3 for kij 0.
  - Run lengthens by 5 cycles; no duplicate write.
- `reset` asserted during EXEC of kij=2, then a fresh `start`:
  - Immediate NOP and IDLE, no `done`.
  - The restart repeats the full 1848-cycle sequence.

Source files
------------

// File: rtl/conv_sequencer.sv
// Instruction sequencer for one convolution tile on `core`: activation preload, per-kij
// weight/L0/execute/drain phases, then psum accumulation with self-computed addresses.
module conv_sequencer #(
    parameter int row        = 8,
    parameter int col        = 8,
    parameter int in_w       = 6,
    parameter int k_w        = 3,
    parameter int wgt_base   = 1024,
    parameter int rst_cycles = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        skip_act,
    output logic [33:0] inst,
    output logic        core_reset,
    output logic        data_req,
    output logic        data_kind,
    output logic [10:0] data_idx,
    input  logic        data_ack,
    output logic        busy,
    output logic        done,
    output logic        out_strobe,
    output logic [4:0]  out_idx
);
    localparam int LEN_NIJ  = in_w * in_w;
    localparam int LEN_KIJ  = k_w * k_w;
    localparam int OUT_W    = in_w - k_w + 1;
    localparam int LEN_ONIJ = OUT_W * OUT_W;

    localparam logic [33:0] NOP    = 34'h1800C0000;
    localparam logic [10:0] C_NIJ  = 11'(LEN_NIJ);
    localparam logic [10:0] C_KIJ  = 11'(LEN_KIJ);
    localparam logic [10:0] C_ONIJ = 11'(LEN_ONIJ);
    localparam logic [10:0] C_OUTW = 11'(OUT_W);
    localparam logic [10:0] C_INW  = 11'(in_w);
    localparam logic [10:0] C_KW   = 11'(k_w);
    localparam logic [10:0] C_ROW  = 11'(row);
    localparam logic [10:0] C_COL  = 11'(col);
    localparam logic [10:0] C_WGT  = 11'(wgt_base);
    localparam logic [10:0] C_RST  = 11'(rst_cycles);

    typedef enum logic [3:0] {
        S_IDLE, S_ACT_WR, S_KRST, S_W_WR, S_W_FIFO, S_W_LOAD, S_W_DRAIN,
        S_L0_WR, S_EXEC, S_GAP, S_OFIFO_RD, S_ACC_RST, S_ACC_RD, S_ACC_END
    } state_t;

    state_t      state_reg, state_next;
    logic [10:0] t_reg, t_next;
    logic [10:0] kij_reg, kij_next;
    logic [10:0] o_reg, o_next;
    logic [10:0] ox_reg, ox_next, oy_reg, oy_next;
    logic [10:0] kx_reg, kx_next, ky_reg, ky_next;
    logic [10:0] state_len;
    logic        last;

    logic [33:0] inst_reg, inst_next;
    logic        core_reset_reg, core_reset_next;
    logic        data_req_reg, data_req_next;
    logic        data_kind_reg, data_kind_next;
    logic [10:0] data_idx_reg, data_idx_next;
    logic        busy_reg, done_reg, fin_reg;
    logic        strobe_pend_reg, out_strobe_reg;
    logic [4:0]  o_pend_reg, out_idx_reg;

    logic        acc, cen_p, wen_p, cen_x, wen_x;
    logic [10:0] a_p, a_x;
    logic [6:0]  ctl;
    logic        stall;

    // The state register runs one cycle ahead of the registered outputs, so a
    // refused write slot freezes both and the slot is re-offered unchanged.
    assign stall = data_req_reg & ~data_ack;

    always_comb begin
        state_len = 11'd1;
        case (state_reg)
            S_ACT_WR:  state_len = C_NIJ;
            S_KRST:    state_len = C_RST + 11'd1;
            S_W_WR:    state_len = C_COL;
            S_W_FIFO:  state_len = C_COL + 11'd1;
            S_W_LOAD:  state_len = C_COL;
            S_W_DRAIN: state_len = 11'd1 + C_ROW + C_COL;
            S_L0_WR:   state_len = C_NIJ + 11'd1;
            S_EXEC:    state_len = C_NIJ + C_ROW + C_COL;
            S_OFIFO_RD: state_len = C_NIJ;
            S_ACC_RD:  state_len = C_KIJ + 11'd1;
            default:   state_len = 11'd1;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg + 11'd1;
        kij_next   = kij_reg;
        o_next     = o_reg;
        ox_next    = ox_reg;
        oy_next    = oy_reg;
        kx_next    = kx_reg;
        ky_next    = ky_reg;
        last       = (t_reg == state_len - 11'd1);
        if (state_reg == S_ACC_RD) begin
            if (kx_reg == C_KW - 11'd1) begin
                kx_next = '0;
                ky_next = ky_reg + 11'd1;
            end else begin
                kx_next = kx_reg + 11'd1;
            end
        end
        if (state_reg == S_IDLE) begin
            t_next = '0;
            if (start && !busy_reg) begin
                state_next = skip_act ? S_KRST : S_ACT_WR;
                kij_next   = '0;
                o_next     = '0;
                ox_next    = '0;
                oy_next    = '0;
            end
        end else if (last) begin
            t_next = '0;
            case (state_reg)
                S_ACT_WR:  state_next = S_KRST;
                S_KRST:    state_next = S_W_WR;
                S_W_WR:    state_next = S_W_FIFO;
                S_W_FIFO:  state_next = S_W_LOAD;
                S_W_LOAD:  state_next = S_W_DRAIN;
                S_W_DRAIN: state_next = S_L0_WR;
                S_L0_WR:   state_next = S_EXEC;
                S_EXEC:    state_next = S_GAP;
                S_GAP:     state_next = S_OFIFO_RD;
                S_OFIFO_RD: begin
                    if (kij_reg == C_KIJ - 11'd1) begin
                        state_next = S_ACC_RST;
                    end else begin
                        state_next = S_KRST;
                        kij_next   = kij_reg + 11'd1;
                    end
                end
                S_ACC_RST: begin
                    state_next = S_ACC_RD;
                    kx_next    = '0;
                    ky_next    = '0;
                end
                S_ACC_RD:  state_next = S_ACC_END;
                S_ACC_END: begin
                    if (o_reg == C_ONIJ - 11'd1) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_ACC_RST;
                        o_next     = o_reg + 11'd1;
                        if (ox_reg == C_OUTW - 11'd1) begin
                            ox_next = '0;
                            oy_next = oy_reg + 11'd1;
                        end else begin
                            ox_next = ox_reg + 11'd1;
                        end
                    end
                end
                default:   state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        acc             = 1'b0;
        cen_p           = 1'b1;
        wen_p           = 1'b1;
        a_p             = '0;
        cen_x           = 1'b1;
        wen_x           = 1'b1;
        a_x             = '0;
        ctl             = '0;
        core_reset_next = 1'b0;
        data_req_next   = 1'b0;
        data_kind_next  = 1'b0;
        data_idx_next   = '0;
        case (state_reg)
            S_ACT_WR: begin
                cen_x         = 1'b0;
                wen_x         = 1'b0;
                a_x           = t_reg;
                data_req_next = 1'b1;
                data_idx_next = t_reg;
            end
            S_KRST:    core_reset_next = (t_reg < C_RST);
            S_W_WR: begin
                cen_x          = 1'b0;
                wen_x          = 1'b0;
                a_x            = C_WGT + t_reg;
                data_req_next  = 1'b1;
                data_kind_next = 1'b1;
                data_idx_next  = kij_reg * C_COL + t_reg;
            end
            S_W_FIFO: begin
                ctl[5] = 1'b1;
                cen_x  = 1'b0;
                a_x    = C_WGT + t_reg;
            end
            S_W_LOAD: begin
                ctl[4] = 1'b1;
                ctl[0] = 1'b1;
            end
            S_W_DRAIN: ctl[0] = 1'b1;
            S_L0_WR: begin
                ctl[2] = 1'b1;
                cen_x  = 1'b0;
                a_x    = t_reg;
            end
            S_EXEC: begin
                ctl[3] = 1'b1;
                ctl[1] = 1'b1;
            end
            S_OFIFO_RD: begin
                ctl[6] = 1'b1;
                cen_p  = 1'b0;
                wen_p  = 1'b0;
                a_p    = kij_reg * C_NIJ + t_reg;
            end
            S_ACC_RST: core_reset_next = 1'b1;
            S_ACC_RD: begin
                // t doubles as the kij being accumulated; the extra final cycle only holds acc
                acc = (t_reg != 11'd0);
                if (t_reg < C_KIJ) begin
                    cen_p = 1'b0;
                    a_p   = t_reg * C_NIJ + (oy_reg + ky_reg) * C_INW + ox_reg + kx_reg;
                end
            end
            default: ;
        endcase
        inst_next = {acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x, ctl};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            t_reg           <= '0;
            kij_reg         <= '0;
            o_reg           <= '0;
            ox_reg          <= '0;
            oy_reg          <= '0;
            kx_reg          <= '0;
            ky_reg          <= '0;
            inst_reg        <= NOP;
            core_reset_reg  <= 1'b0;
            data_req_reg    <= 1'b0;
            data_kind_reg   <= 1'b0;
            data_idx_reg    <= '0;
            busy_reg        <= 1'b0;
            fin_reg         <= 1'b0;
            done_reg        <= 1'b0;
            strobe_pend_reg <= 1'b0;
            o_pend_reg      <= '0;
            out_strobe_reg  <= 1'b0;
            out_idx_reg     <= '0;
        end else if (!stall) begin
            state_reg       <= state_next;
            t_reg           <= t_next;
            kij_reg         <= kij_next;
            o_reg           <= o_next;
            ox_reg          <= ox_next;
            oy_reg          <= oy_next;
            kx_reg          <= kx_next;
            ky_reg          <= ky_next;
            inst_reg        <= inst_next;
            core_reset_reg  <= core_reset_next;
            data_req_reg    <= data_req_next;
            data_kind_reg   <= data_kind_next;
            data_idx_reg    <= data_idx_next;
            busy_reg        <= (state_reg != S_IDLE);
            fin_reg         <= (state_reg == S_ACC_END) && (o_reg == C_ONIJ - 11'd1);
            done_reg        <= fin_reg;
            strobe_pend_reg <= (state_reg == S_ACC_END);
            if (state_reg == S_ACC_END) begin
                o_pend_reg <= o_reg[4:0];
            end
            out_strobe_reg  <= strobe_pend_reg;
            if (strobe_pend_reg) begin
                out_idx_reg <= o_pend_reg;
            end
        end
    end

    // A refused slot must not write, so the offered word is masked to NOP
    genvar gi;
    generate
        for (gi = 0; gi < 34; gi++) begin : g_inst
            assign inst[gi] = stall ? NOP[gi] : inst_reg[gi];
        end
    endgenerate

    assign core_reset = core_reset_reg;
    assign data_req   = data_req_reg;
    assign data_kind  = data_kind_reg;
    assign data_idx   = data_idx_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign out_strobe = out_strobe_reg;
    assign out_idx    = out_idx_reg;
endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer: a flat per-cycle expected stream built from the phase rules,
// compared every cycle, with stalls, skip_act, random acks and a mid-run reset.
module tb_conv_sequencer;
    localparam int ROW = 8, COL = 8, IN_W = 6, K_W = 3, WGT = 1024, RST = 11;
    localparam int NIJ = IN_W * IN_W, KIJ = K_W * K_W, OW = IN_W - K_W + 1, ONIJ = OW * OW;
    localparam logic [33:0] NOP_W = 34'h1800C0000;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, skip_act = 1'b0, data_ack = 1'b1;
    logic [33:0] inst;
    logic        core_reset, data_req, data_kind, busy, done, out_strobe;
    logic [10:0] data_idx;
    logic [4:0]  out_idx;

    conv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .skip_act(skip_act),
        .inst(inst), .core_reset(core_reset), .data_req(data_req), .data_kind(data_kind),
        .data_idx(data_idx), .data_ack(data_ack), .busy(busy), .done(done),
        .out_strobe(out_strobe), .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [33:0] w;
        bit cr, req, kind, bsy, dn, stb;
        int idx, oidx;
    } ent_t;

    ent_t exp_q[$];
    ent_t ce;
    int   total = 0, bad = 0, ptr = 0;
    bit   run_active = 0, stb_pend = 0;
    int   stb_o = 0;
    int   busy_cnt = 0, done_cnt = 0, strobe_cnt = 0, act_wr = 0, wgt_wr = 0;
    int   stall_cnt = 0, idx3_nop = 0, act_req = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s (entry %0d): got %0h expected %0h", name, ptr, act, expv);
        end
    endtask

    function automatic logic [33:0] mk(bit acc, bit cenp, bit wenp, int ap, bit cenx, bit wenx,
                                       int ax, logic [6:0] ctl);
        logic [10:0] a1, a2;
        a1 = ap[10:0];
        a2 = ax[10:0];
        return {acc, cenp, wenp, a1, cenx, wenx, a2, ctl};
    endfunction

    function automatic int acc_addr(int o, int j);
        int ky, kx, oy, ox;
        ky = j / K_W; kx = j % K_W; oy = o / OW; ox = o % OW;
        return j * NIJ + (oy + ky) * IN_W + ox + kx;
    endfunction

    task automatic push(input logic [33:0] w, input bit cr, input bit req, input bit kind, input int idx);
        ent_t e;
        e.w = w; e.cr = cr; e.req = req; e.kind = kind; e.idx = idx;
        e.bsy = 1; e.dn = 0; e.stb = stb_pend; e.oidx = stb_o;
        stb_pend = 0;
        exp_q.push_back(e);
    endtask

    task automatic build_model(input bit skip);
        ent_t e;
        exp_q.delete();
        stb_pend = 0;
        if (!skip)
            for (int n = 0; n < NIJ; n++) push(mk(0,1,1,0,0,0,n,7'h00), 0, 1, 0, n);
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i < RST; i++) push(NOP_W, 1, 0, 0, 0);
            push(NOP_W, 0, 0, 0, 0);
            for (int t = 0; t < COL; t++) push(mk(0,1,1,0,0,0,WGT+t,7'h00), 0, 1, 1, k*COL+t);
            for (int t = 0; t <= COL; t++) push(mk(0,1,1,0,0,1,WGT+t,7'h20), 0, 0, 0, 0);
            for (int t = 0; t < COL; t++) push(mk(0,1,1,0,1,1,0,7'h11), 0, 0, 0, 0);
            for (int t = 0; t < 1+ROW+COL; t++) push(mk(0,1,1,0,1,1,0,7'h01), 0, 0, 0, 0);
            for (int t = 0; t <= NIJ; t++) push(mk(0,1,1,0,0,1,t,7'h04), 0, 0, 0, 0);
            for (int t = 0; t < NIJ+ROW+COL; t++) push(mk(0,1,1,0,1,1,0,7'h0A), 0, 0, 0, 0);
            push(NOP_W, 0, 0, 0, 0);
            for (int t = 0; t < NIJ; t++) push(mk(0,0,0,k*NIJ+t,1,1,0,7'h40), 0, 0, 0, 0);
        end
        for (int o = 0; o < ONIJ; o++) begin
            push(NOP_W, 1, 0, 0, 0);
            for (int j = 0; j <= KIJ; j++) begin
                if (j < KIJ) push(mk(j >= 1, 0, 1, acc_addr(o, j), 1, 1, 0, 7'h00), 0, 0, 0, 0);
                else         push(mk(1, 1, 1, 0, 1, 1, 0, 7'h00), 0, 0, 0, 0);
            end
            push(NOP_W, 0, 0, 0, 0);
            stb_pend = 1;
            stb_o = o;
        end
        e.w = NOP_W; e.cr = 0; e.req = 0; e.kind = 0; e.idx = 0;
        e.bsy = 0; e.dn = 1; e.stb = stb_pend; e.oidx = stb_o;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (data_req && !data_kind) act_req++;
        if (inst[19:18] == 2'b00) begin
            if (inst[17:7] >= 11'd1024) wgt_wr++;
            else act_wr++;
        end
        if (out_strobe) begin
            check("strobe_order", out_idx, strobe_cnt);
            strobe_cnt++;
        end
        if (run_active && ptr < exp_q.size()) begin
            ce = exp_q[ptr];
            if (ce.req && !data_ack) begin
                check("stall_inst", inst, NOP_W);
                check("stall_req", data_req, 1);
                check("stall_idx", data_idx, ce.idx);
                check("stall_busy", busy, 1);
                stall_cnt++;
                if (data_idx == 11'd3 && inst == NOP_W) idx3_nop++;
            end else begin
                check("inst", inst, ce.w);
                check("core_reset", core_reset, ce.cr);
                check("data_req", data_req, ce.req);
                if (ce.req) begin
                    check("data_kind", data_kind, ce.kind);
                    check("data_idx", data_idx, ce.idx);
                end
                check("busy", busy, ce.bsy);
                check("done", done, ce.dn);
                check("out_strobe", out_strobe, ce.stb);
                if (ce.stb) check("out_idx", out_idx, ce.oidx);
                ptr++;
            end
        end
    end

    task automatic do_run(input bit skip, input int mode, input int model_lit, input int abort_at,
                          input string tag);
        int cyc;
        int drop_left;
        build_model(skip);
        check("model_len", exp_q.size() - 1, model_lit);
        drop_left = 5;
        busy_cnt = 0; done_cnt = 0; strobe_cnt = 0; act_wr = 0; wgt_wr = 0;
        stall_cnt = 0; idx3_nop = 0; act_req = 0;
        @(posedge clk); #1;
        start = 1; skip_act = skip; data_ack = 1;
        @(posedge clk); #1;
        start = 0; skip_act = 0;
        @(posedge clk); #1;
        ptr = 0; run_active = 1;
        cyc = 0;
        while (ptr < exp_q.size() && cyc < 8000) begin
            if (abort_at > 0 && ptr >= abort_at) break;
            if (mode == 1) data_ack = ($urandom_range(0, 3) != 0);
            else if (mode == 2) begin
                if (data_req && data_kind && data_idx == 11'd3 && drop_left > 0) begin
                    data_ack = 0;
                    drop_left--;
                end else data_ack = 1;
            end else data_ack = 1;
            @(posedge clk); #1;
            cyc++;
        end
        run_active = 0;
        data_ack = 1;
        if (abort_at > 0) begin
            reset = 1;
            @(posedge clk); #1;
            reset = 0;
            check("abort_inst", inst, NOP_W);
            check("abort_busy", busy, 0);
            check("abort_req", data_req, 0);
            check("abort_core_reset", core_reset, 0);
            check("abort_strobe", out_strobe, 0);
            done_cnt = 0; busy_cnt = 0;
            repeat (4) @(posedge clk);
            #1;
            check("abort_no_done", done_cnt, 0);
            check("abort_stays_idle", busy_cnt, 0);
            $display("run %s: reset at entry %0d", tag, ptr);
            return;
        end
        check("run_complete", ptr, exp_q.size());
        @(posedge clk); #1;
        check("busy_len", busy_cnt, model_lit + stall_cnt);
        check("done_pulses", done_cnt, 1);
        check("strobe_count", strobe_cnt, 16);
        check("act_writes", act_wr, skip ? 0 : 36);
        check("wgt_writes", wgt_wr, 72);
        if (skip) check("act_requests", act_req, 0);
        if (mode == 2) begin
            check("stall_cycles", stall_cnt, 5);
            check("stall_idx3_nops", idx3_nop, 5);
            check("busy_len_stalled", busy_cnt, 1853);
        end
        $display("run %s: busy=%0d stalls=%0d strobes=%0d", tag, busy_cnt, stall_cnt, strobe_cnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", inst, NOP_W);
        check("rst_core_reset", core_reset, 0);
        check("rst_data_req", data_req, 0);
        check("rst_data_kind", data_kind, 0);
        check("rst_data_idx", data_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_strobe", out_strobe, 0);
        check("rst_out_idx", out_idx, 0);
        reset = 0;
        check("model_addr_o5_j4", acc_addr(5, 4), 158);
        check("model_addr_o15_j8", acc_addr(15, 8), 323);
        do_run(0, 0, 1848, 0,   "default");
        do_run(1, 0, 1812, 0,   "skip_act");
        do_run(0, 2, 1848, 0,   "stall5");
        do_run(0, 1, 1848, 0,   "random_ack");
        do_run(0, 0, 1848, 500, "reset_in_exec");
        do_run(0, 0, 1848, 0,   "restart");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
